endecoder_rounds: RTL and testbench

Parametrised iterative multi-round encrypt/decrypt engine. It is the next generation of the fixed 4-bit single-shot EnDecoder core. It adds generic data/key width, a configurable round count and rotation, a busy indication, and a guaranteed decrypt-inverts-encrypt property. It sits behind the TinyTapeout top wrapper, which packs its data/key/control onto ui_in/uio_in and its results onto uo_out.

---
 rtl/endecoder_rounds.sv | 164 ++++++++++++++++
 tb/tb_endecoder_rounds.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/endecoder_rounds.sv
// endecoder_rounds
// ----------------
// Iterative multi-round encrypt/decrypt engine. The caller starts an operation
// with start_i. The engine latches code_i, key_i and mode_i, then applies
// ROUNDS cipher rounds. When it finishes it updates code_o and pulses done_o
// for one cycle. Decrypt runs the rounds in reverse order, so decrypting an
// encrypted word returns the original word.
//
// Round r uses the round key k_r = rotl(key, r mod DATA_W):
//   encrypt: x <- rotl((x ^ k_r) + r, ROT)    for r = 0 .. ROUNDS-1
//   decrypt: x <- (rotr(x, ROT) - r) ^ k_r    for r = ROUNDS-1 .. 0
//
// Optional build macro ENDEC_UNROLL2_EN: when it is defined, each RUN cycle
// applies two rounds (one round in the last cycle if ROUNDS is odd). The
// results are bit-identical to the default one-round-per-cycle build.
//
// Ports:
//   clk_i    system clock, all logic on the rising edge
//   rst_i    synchronous active-high reset
//   start_i  request, accepted only while busy_o = 0
//   mode_i   0 = encrypt, 1 = decrypt (sampled with start_i)
//   code_i   plaintext/ciphertext (sampled with start_i)
//   key_i    key (sampled with start_i)
//   busy_o   high while rounds are executing
//   code_o   result, held until the next done_o
//   done_o   one-cycle pulse when code_o is updated
module endecoder_rounds #(
  parameter int DATA_W = 8,
  parameter int ROUNDS = 4,
  parameter int ROT    = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [DATA_W-1:0] code_i,
  input  logic [DATA_W-1:0] key_i,
  output logic              busy_o,
  output logic [DATA_W-1:0] code_o,
  output logic              done_o
);

  localparam int CW = $clog2(ROUNDS) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state_q;
  logic [DATA_W-1:0] x_q;
  logic [DATA_W-1:0] key_q;
  logic              mode_q;
  logic [CW-1:0]     r_q;
  logic [DATA_W-1:0] code_q;
  logic              done_q;

  logic [DATA_W-1:0] x_one;
  logic [DATA_W-1:0] x_run;
  logic              last_run;
  int unsigned       r_cur;
  int unsigned       r_nxt1;
  int unsigned       r_step;
  int unsigned       remaining;
`ifdef ENDEC_UNROLL2_EN
  logic [DATA_W-1:0] x_two;
`endif

  // The rotation is built by shifting a doubled copy of the word. An amount of
  // zero (or a multiple of DATA_W) returns v unchanged.
  function automatic logic [DATA_W-1:0] rotl_f(input logic [DATA_W-1:0] v,
                                               input int unsigned amt);
    logic [2*DATA_W-1:0] d;
    d = {v, v} << (amt % DATA_W);
    return d[2*DATA_W-1:DATA_W];
  endfunction

  // Applies one cipher round in either direction. The round index is
  // truncated to DATA_W bits before it is added or subtracted.
  function automatic logic [DATA_W-1:0] round_f(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] key,
                                                input int unsigned r,
                                                input logic dec);
    logic [DATA_W-1:0] k;
    logic [DATA_W-1:0] ri;
    logic [DATA_W-1:0] t;
    k  = rotl_f(key, r);
    ri = DATA_W'(r);
    if (dec) begin
      t = rotl_f(x, DATA_W - ROT) - ri;
      return t ^ k;
    end
    t = (x ^ k) + ri;
    return rotl_f(t, ROT);
  endfunction

  // Round datapath for the current RUN cycle. remaining counts the rounds that
  // are still to be applied, including the round at index r_q. This works in
  // both directions, so the "last cycle" test does not depend on the mode.
  always_comb begin
    r_cur     = 32'(r_q);
    remaining = mode_q ? r_cur + 1 : ROUNDS - r_cur;
    r_nxt1    = mode_q ? r_cur - 1 : r_cur + 1;
    x_one     = round_f(x_q, key_q, r_cur, mode_q);
    x_run     = x_one;
    r_step    = r_nxt1;
    last_run  = (remaining <= 1);
`ifdef ENDEC_UNROLL2_EN
    // The second round's result is discarded when only one round is left.
    x_two = round_f(x_one, key_q, r_nxt1, mode_q);
    if (remaining >= 2) begin
      x_run    = x_two;
      r_step   = mode_q ? r_cur - 2 : r_cur + 2;
      last_run = (remaining == 2);
    end
`endif
  end

  // Control FSM and state registers. DONE accepts a new start the same way
  // IDLE does, which allows back-to-back operations with no idle gap. The
  // round counter stops stepping on the last round, so it never leaves
  // 0..ROUNDS-1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      x_q     <= '0;
      key_q   <= '0;
      mode_q  <= 1'b0;
      r_q     <= '0;
      code_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            x_q     <= code_i;
            key_q   <= key_i;
            mode_q  <= mode_i;
            r_q     <= mode_i ? CW'(ROUNDS - 1) : '0;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          x_q <= x_run;
          if (last_run) begin
            code_q  <= x_run;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            r_q <= CW'(r_step);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o = (state_q == RUN);
  assign code_o = code_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_endecoder_rounds.sv
// tb_endecoder_rounds
// -------------------
// Bench for endecoder_rounds. It instantiates two configurations: the default
// 8-bit / 4-round / rot-1 core and a 12-bit / 7-round / rot-5 core. Expected
// values come from a fixed vector table and from a reference cipher that
// follows the round equations directly, using integer arithmetic.
module tb_endecoder_rounds;

`ifdef ENDEC_UNROLL2_EN
  localparam int LAT_A = 3;
  localparam int LAT_B = 5;
`else
  localparam int LAT_A = 5;
  localparam int LAT_B = 8;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start_a = 1'b0;
  logic        mode_a  = 1'b0;
  logic [7:0]  code_a  = '0;
  logic [7:0]  key_a   = '0;
  logic        busy_a;
  logic [7:0]  out_a;
  logic        done_a;

  logic        start_b = 1'b0;
  logic        mode_b  = 1'b0;
  logic [11:0] code_b  = '0;
  logic [11:0] key_b   = '0;
  logic        busy_b;
  logic [11:0] out_b;
  logic        done_b;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  endecoder_rounds dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .mode_i(mode_a),
    .code_i(code_a), .key_i(key_a), .busy_o(busy_a), .code_o(out_a),
    .done_o(done_a)
  );

  endecoder_rounds #(.DATA_W(12), .ROUNDS(7), .ROT(5)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .mode_i(mode_b),
    .code_i(code_b), .key_i(key_b), .busy_o(busy_b), .code_o(out_b),
    .done_o(done_b)
  );

  // Reference model: plain rotate on integers, masked to w bits.
  function automatic int unsigned mRotl(int unsigned v, int s, int w);
    int unsigned mask;
    int sh;
    mask = (32'd1 << w) - 1;
    sh = s % w;
    if (sh == 0) return v & mask;
    return ((v << sh) | ((v & mask) >> (w - sh))) & mask;
  endfunction

  function automatic int unsigned mCipher(int unsigned x, int unsigned key,
                                          bit dec, int w, int rounds, int rot);
    int unsigned mask;
    int unsigned v;
    mask = (32'd1 << w) - 1;
    v = x & mask;
    if (!dec) begin
      for (int r = 0; r < rounds; r++)
        v = mRotl(((v ^ mRotl(key, r, w)) + r) & mask, rot, w);
    end else begin
      for (int r = rounds - 1; r >= 0; r--)
        v = ((mRotl(v, w - rot, w) - r) & mask) ^ mRotl(key, r, w);
    end
    return v;
  endfunction

  task automatic checkOutput(input string name, input longint actual,
                             input longint expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Runs one operation on the 8-bit core. Inputs are scrambled during RUN to
  // show that they are ignored. lat counts cycles from the start edge up to
  // the edge that samples done_o high. busyCycles counts cycles with busy_o high.
  task automatic applyStimulus(input bit mode, input logic [7:0] code,
                               input logic [7:0] key, output logic [7:0] res,
                               output int lat, output int busyCycles);
    @(negedge clk);
    start_a = 1'b1; mode_a = mode; code_a = code; key_a = key;
    @(negedge clk);
    start_a = 1'b0; mode_a = 1'($urandom); code_a = 8'($urandom); key_a = 8'($urandom);
    lat = 1; busyCycles = 0;
    forever begin
      if (busy_a) busyCycles++;
      if (done_a) break;
      if (lat >= 40) begin
        checkOutput("timeout_a", 0, 1);
        break;
      end
      @(negedge clk);
      lat++;
    end
    res = out_a;
  endtask

  task automatic applyStimulusWide(input bit mode, input logic [11:0] code,
                                   input logic [11:0] key, output logic [11:0] res,
                                   output int lat);
    @(negedge clk);
    start_b = 1'b1; mode_b = mode; code_b = code; key_b = key;
    @(negedge clk);
    start_b = 1'b0; code_b = 12'($urandom); key_b = 12'($urandom);
    lat = 1;
    forever begin
      if (done_b) break;
      if (lat >= 40) begin
        checkOutput("timeout_b", 0, 1);
        break;
      end
      @(negedge clk);
      lat++;
    end
    res = out_b;
  endtask

  typedef struct {
    string      name;
    bit         mode;
    logic [7:0] code;
    logic [7:0] key;
    logic [7:0] expect_v;
  } vec_t;

  initial begin
    vec_t vecs[6];
    logic [7:0]  res;
    logic [11:0] resB;
    logic [11:0] x;
    logic [11:0] k;
    logic [11:0] enc;
    int lat;
    int busyCycles;
    int doneSeen;
    int doneIdx[2];
    logic [7:0] doneVal[2];

    vecs[0] = '{"enc_00_00", 1'b0, 8'h00, 8'h00, 8'h16};
    vecs[1] = '{"enc_a5_01", 1'b0, 8'hA5, 8'h01, 8'h70};
    vecs[2] = '{"dec_70_01", 1'b1, 8'h70, 8'h01, 8'hA5};
    vecs[3] = '{"dec_16_00", 1'b1, 8'h16, 8'h00, 8'h00};
    vecs[4] = '{"enc_ff_ff", 1'b0, 8'hFF, 8'hFF, 8'h00};
    vecs[5] = '{"dec_00_ff", 1'b1, 8'h00, 8'hFF, 8'hFF};

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_busy_a", busy_a, 0);
    checkOutput("reset_done_a", done_a, 0);
    checkOutput("reset_code_a", out_a, 0);
    checkOutput("reset_code_b", out_b, 0);

    // Table vectors, with latency, busy length and single-cycle done pulse
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].mode, vecs[i].code, vecs[i].key, res, lat, busyCycles);
      checkOutput({vecs[i].name, "_code"}, res, vecs[i].expect_v);
      checkOutput({vecs[i].name, "_latency"}, lat, LAT_A);
      checkOutput({vecs[i].name, "_busy_cycles"}, busyCycles, LAT_A - 1);
      @(negedge clk);
      checkOutput({vecs[i].name, "_done_single"}, done_a, 0);
      checkOutput({vecs[i].name, "_code_hold"}, out_a, vecs[i].expect_v);
    end

    // Random round-trips on the default core
    for (int i = 0; i < 20; i++) begin
      x = 12'($urandom_range(0, 255));
      k = 12'($urandom_range(0, 255));
      applyStimulus(1'b0, x[7:0], k[7:0], res, lat, busyCycles);
      checkOutput("rand_a_enc", res, mCipher(x, k, 1'b0, 8, 4, 1));
      applyStimulus(1'b1, res, k[7:0], res, lat, busyCycles);
      checkOutput("rand_a_roundtrip", res, x[7:0]);
    end

    // Start held high: second op is accepted in the DONE cycle with the code
    // value present then. Each op gets its own done pulse.
    @(negedge clk);
    start_a = 1'b1; mode_a = 1'b0; code_a = 8'hA5; key_a = 8'h01;
    @(negedge clk);
    code_a = 8'h11;
    doneSeen = 0;
    for (int idx = 1; idx <= 3 * LAT_A; idx++) begin
      if (done_a && doneSeen < 2) begin
        doneIdx[doneSeen] = idx;
        doneVal[doneSeen] = out_a;
        doneSeen++;
      end
      @(negedge clk);
      if (doneSeen >= 1) start_a = 1'b0;
    end
    checkOutput("held_done_count", doneSeen, 2);
    if (doneSeen == 2) begin
      checkOutput("held_first_idx", doneIdx[0], LAT_A);
      checkOutput("held_first_code", doneVal[0], 8'h70);
      checkOutput("held_second_idx", doneIdx[1], 2 * LAT_A);
      checkOutput("held_second_code", doneVal[1], mCipher(32'h11, 32'h01, 1'b0, 8, 4, 1));
    end

    // Reset in the middle of RUN aborts the op
    @(negedge clk);
    start_a = 1'b1; mode_a = 1'b0; code_a = 8'h3C; key_a = 8'h5A;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", busy_a, 0);
    checkOutput("abort_code", out_a, 0);
    doneSeen = 0;
    for (int i = 0; i < 8; i++) begin
      if (done_a) doneSeen++;
      @(negedge clk);
    end
    checkOutput("abort_no_done", doneSeen, 0);
    applyStimulus(1'b0, 8'h3C, 8'h5A, res, lat, busyCycles);
    checkOutput("after_abort_code", res, mCipher(32'h3C, 32'h5A, 1'b0, 8, 4, 1));
    checkOutput("after_abort_latency", lat, LAT_A);

    // Wide core sweep: encrypt against the model, then decrypt back
    for (int i = 0; i < 1000; i++) begin
      x = 12'($urandom);
      k = 12'($urandom);
      applyStimulusWide(1'b0, x, k, resB, lat);
      enc = resB;
      checkOutput("wide_enc", enc, mCipher(x, k, 1'b0, 12, 7, 5));
      checkOutput("wide_enc_latency", lat, LAT_B);
      applyStimulusWide(1'b1, enc, k, resB, lat);
      checkOutput("wide_roundtrip", resB, x);
      checkOutput("wide_dec_latency", lat, LAT_B);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
